fifo_flex: RTL and testbench
============================

Name: fifo_flex

Overview:
Synchronous single-clock valid/ready FIFO, next generation of the team's basic stream FIFO. Adds arbitrary (non-power-of-two) depth, an occupancy count output, programmable almost-full/almost-empty flags and a synchronous flush. Sits between stream producers and consumers in the datapath. First-word-fall-through: head entry is presented on deq_data while deq_valid=1.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DEPTH, 12, number of entries; any integer >=2, power of two not required
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
CW (localparam), $clog2(DEPTH+1), count width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
flush  in  1  synchronous discard of all stored entries
enq_valid  in  1  producer has data
enq_data  in  DATA_WIDTH  producer payload
enq_ready  out  1  FIFO can accept an entry this cycle
deq_ready  in  1  consumer accepts head entry
deq_data  out  DATA_WIDTH  head entry payload
deq_valid  out  1  head entry valid
count  out  CW  current occupancy, 0..DEPTH
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH

Behaviour:
- State: write_ptr, read_ptr (each $clog2(DEPTH) bits, range 0..DEPTH-1), count register (CW bits), storage array DEPTH x DATA_WIDTH. Storage not reset.
- Reset (reset=1 at rising edge): write_ptr=0, read_ptr=0, count=0. Outputs after reset: enq_ready=1, deq_valid=0, count=0, almost_full=(AF_THRESH==0 ? 1 : 0), almost_empty=1. deq_data don't-care while deq_valid=0.
- reset has priority over flush, flush over enq/deq. Reset or flush mid-stream drops all entries and any transfer in that cycle; no transfer is considered to have occurred (producer sees handshake but data is discarded – producers must not rely on flush-cycle transfers).
- enq_ready = (count != DEPTH); deq_valid = (count != 0). Both derived only from registered state; no combinational path from enq_valid/deq_ready to any output.
- Enqueue fires when enq_valid && enq_ready: mem[write_ptr] <= enq_data; write_ptr advances.
- Dequeue fires when deq_valid && deq_ready: read_ptr advances.
- Pointer advance: ptr == DEPTH-1 -> 0, else ptr+1 (explicit wrap, not modulo 2^n).
- count next: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Simultaneous enq+deq with 0<count<DEPTH: both fire, count unchanged, ordering preserved.
- Full (count=DEPTH): enq_ready=0 even if deq_ready=1 that cycle; deq fires, enq_ready=1 next cycle.
- Empty (count=0): deq_valid=0; no bypass. Latency enq handshake -> deq_valid=1 is exactly 1 cycle.
- deq_data = mem[read_ptr], combinational read; stable while deq_valid=1 and deq_ready=0.
- almost_full/almost_empty: combinational compares on registered count, update same cycle as count.
- Strict FIFO order; no entry duplicated or lost except via flush/reset.

Test Plan:
- Fill: DEPTH=12, deq_ready=0, enqueue 0x00..0x0B back-to-back -> enq_ready=0 after 12th accept, count=12, almost_full=1 from count=10, deq_data=0x00; 13th value 0x0C not accepted.
- Drain and order: from full, deq_ready=1 for 12 cycles -> deq_data 0x00..0x0B in order, deq_valid=0 after last, count=0, almost_empty=1 at count<=2.
- Wrap-around: 40 random-length bursts with random enq_valid/deq_ready (50%) -> scoreboard matches exactly, pointers cross 11->0 at least 3 times, count never exceeds 12.
- Full + simultaneous: count=12, enq_valid=1 (0xAA), deq_ready=1 -> dequeue only, count=11; next cycle 0xAA accepted with deq_ready=1 -> count stays 11.
- Empty latency: count=0, enqueue 0x5A in cycle t -> deq_valid=1 with deq_data=0x5A at t+1, not at t.
- Flush/reset mid-operation: count=7, assert flush with enq_valid=1 -> next cycle count=0, deq_valid=0, enq_ready=1; repeat using reset -> same result; subsequent enqueue 0x33 dequeues as 0x33.

Source files
------------

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock valid/ready stream FIFO with arbitrary depth,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
// First-word-fall-through: the head entry is visible on deq_data whenever
// deq_valid is high. All handshake outputs derive from registered state only.
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  enq_ready,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic                  deq_valid,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_THRESH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic enq_fire;
  logic deq_fire;
  logic discard;

  // Handshake status and flags, purely from registered occupancy
  always_comb begin
    enq_ready    = (count_q != COUNT_FULL);
    deq_valid    = (count_q != '0);
    count        = count_q;
    almost_full  = (count_q >= AF_LEVEL);
    almost_empty = (count_q <= AE_LEVEL);
    deq_data     = mem_q[rd_ptr_q];
  end

  // Transfer qualification; reset and flush cancel any transfer this cycle
  always_comb begin
    discard  = reset || flush;
    enq_fire = enq_valid && enq_ready && !discard;
    deq_fire = deq_valid && deq_ready && !discard;
  end

  // Next-state pointers and occupancy; wrap is explicit at DEPTH-1 so any
  // depth works, not only powers of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (discard) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; the array itself is never reset
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_q[wr_ptr_q] <= enq_data;
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Testbench for fifo_flex: directed fill/drain/full/empty/flush/reset steps
// followed by random traffic, all checked against a queue-based model.
module tb_fifo_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 12;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          flush;
  logic          enq_valid;
  logic [DW-1:0] enq_data;
  logic          enq_ready;
  logic          deq_ready;
  logic [DW-1:0] deq_data;
  logic          deq_valid;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;

  int total = 0;
  int bad   = 0;
  int enq_total = 0;

  logic [DW-1:0] model_q [$];

  fifo_flex #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_data     (enq_data),
    .enq_ready    (enq_ready),
    .deq_ready    (deq_ready),
    .deq_data     (deq_data),
    .deq_valid    (deq_valid),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = model_q.size();
    chk("count",        32'(count),        32'(n));
    chk("enq_ready",    32'(enq_ready),    32'(n != DEPTH));
    chk("deq_valid",    32'(deq_valid),    32'(n != 0));
    chk("almost_full",  32'(almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    if (n != 0) chk("deq_data", 32'(deq_data), 32'(model_q[0]));
  endtask

  // One clock: decide transfers from the model occupancy, advance, compare.
  task automatic cycle();
    bit ef, df;
    ef = enq_valid && (model_q.size() < DEPTH);
    df = deq_ready && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (reset || flush) begin
      model_q.delete();
    end else begin
      if (df) void'(model_q.pop_front());
      if (ef) begin
        model_q.push_back(enq_data);
        enq_total++;
      end
    end
    check_outputs();
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_enq_ready", 32'(enq_ready), 32'd1);
    chk("reset_deq_valid", 32'(deq_valid), 32'd0);
    chk("reset_almost_empty", 32'(almost_empty), 32'd1);
    chk("reset_almost_full", 32'(almost_full), 32'd0);

    // Fill 0x00..0x0B with no consumer
    for (int i = 0; i < DEPTH; i++) begin
      enq_valid = 1'b1; enq_data = DW'(i);
      cycle();
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 10));
    end
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_count", 32'(count), 32'd12);
    chk("full_head", 32'(deq_data), 32'h00);
    enq_data = 8'h0C;
    cycle();
    chk("full_reject_count", 32'(count), 32'd12);
    enq_valid = 1'b0;

    // Drain in order
    deq_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", 32'(deq_data), 32'(i));
      cycle();
      chk("drain_ae", 32'(almost_empty), 32'((DEPTH - 1 - i) <= 2));
    end
    chk("drain_empty", 32'(deq_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    deq_ready = 1'b0;

    // Full with simultaneous enq+deq: only the dequeue fires
    for (int i = 0; i < DEPTH; i++) begin
      enq_valid = 1'b1; enq_data = DW'(8'h10 + i);
      cycle();
    end
    enq_data = 8'hAA; deq_ready = 1'b1;
    cycle();
    chk("fullsim_count", 32'(count), 32'd11);
    chk("fullsim_ready", 32'(enq_ready), 32'd1);
    cycle();
    chk("fullsim_accept_count", 32'(count), 32'd11);
    enq_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle();
    chk("fullsim_drained", 32'(count), 32'd0);
    deq_ready = 1'b0;

    // Empty latency: visible exactly one cycle after the handshake
    enq_valid = 1'b1; enq_data = 8'h5A;
    chk("lat_before", 32'(deq_valid), 32'd0);
    cycle();
    enq_valid = 1'b0;
    chk("lat_valid", 32'(deq_valid), 32'd1);
    chk("lat_data", 32'(deq_data), 32'h5A);
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;

    // Flush mid-stream, then reset mid-stream
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 7; i++) begin
        enq_valid = 1'b1; enq_data = DW'(8'h60 + i);
        cycle();
      end
      chk("pre_discard_count", 32'(count), 32'd7);
      enq_data = 8'hEE;
      if (pass == 0) flush = 1'b1; else reset = 1'b1;
      cycle();
      idle();
      chk("discard_count", 32'(count), 32'd0);
      chk("discard_deq_valid", 32'(deq_valid), 32'd0);
      chk("discard_enq_ready", 32'(enq_ready), 32'd1);
    end
    enq_valid = 1'b1; enq_data = 8'h33;
    cycle();
    enq_valid = 1'b0; deq_ready = 1'b1;
    chk("post_discard_data", 32'(deq_data), 32'h33);
    cycle();
    deq_ready = 1'b0;

    // Random bursts with 50% valid/ready
    enq_total = 0;
    for (int b = 0; b < 40; b++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int c = 0; c < len; c++) begin
        enq_valid = 1'($urandom % 2);
        deq_ready = 1'($urandom % 2);
        enq_data  = DW'($urandom);
        cycle();
      end
    end
    chk("wrap_coverage", 32'(enq_total >= 3 * DEPTH), 32'd1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
